// File: rtl/mem_port_arbiter.sv
// Purpose : shares one variable-latency memory port between data access (served first) and instruction fetch.
// Latency : zero-wait memory gives 3 cycles for fetch only and 4 cycles for data + fetch; no request gives 0 cycles.
// Backpressure: o_stall is held high until every access of the step completes; the bus waits on i_busReady.
//
// Ports:
//   clk, reset_x                    clock (rising edge), synchronous active-low reset
//   Fi_req, Fi_addr                 fetch request and PC
//   Mi_read/Mi_write/Mi_addr/
//   Mi_writeData/Mi_memSize         data request (write wins when both read and write are set)
//   i_busReady, i_busRData          memory completion and read data
//   o_bus*                          memory transaction request
//   Fo_inst, Mo_readData            last captured instruction and raw load word (registered)
//   o_stall, o_timeout              pipeline hold and sticky watchdog flag
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter logic [1:0]  FETCH_SIZE  = 2'b10
) (
  input  logic        clk,
  input  logic        reset_x,
  input  logic        Fi_req,
  input  logic [31:0] Fi_addr,
  input  logic        Mi_read,
  input  logic        Mi_write,
  input  logic [31:0] Mi_addr,
  input  logic [31:0] Mi_writeData,
  input  logic [1:0]  Mi_memSize,
  input  logic        i_busReady,
  input  logic [31:0] i_busRData,
  output logic        o_busValid,
  output logic        o_busWrite,
  output logic [31:0] o_busAddr,
  output logic [31:0] o_busWData,
  output logic [1:0]  o_busSize,
  output logic [31:0] Fo_inst,
  output logic [31:0] Mo_readData,
  output logic        o_stall,
  output logic        o_timeout
);

  typedef enum logic [1:0] {IDLE, DATA, FETCH, DONE} state_t;

  // Counter is just wide enough to reach TIMEOUT_CYC; it saturates at all-ones.
  localparam int unsigned CW = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] WD_LIMIT = CW'(TIMEOUT_CYC);

  state_t        state_q, state_d;
  logic [31:0]   maddr_q, maddr_d;
  logic [31:0]   mwdata_q, mwdata_d;
  logic [1:0]    msize_q, msize_d;
  logic          mwrite_q, mwrite_d;
  logic [31:0]   faddr_q, faddr_d;
  logic          freq_q, freq_d;
  logic [31:0]   inst_q, inst_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          timeout_q, timeout_d;
  logic          bus_wait;

  assign Fo_inst     = inst_q;
  assign Mo_readData = rdata_q;
  assign o_timeout   = timeout_q;

  always_comb begin
    state_d    = state_q;
    maddr_d    = maddr_q;
    mwdata_d   = mwdata_q;
    msize_d    = msize_q;
    mwrite_d   = mwrite_q;
    faddr_d    = faddr_q;
    freq_d     = freq_q;
    inst_d     = inst_q;
    rdata_d    = rdata_q;
    timeout_d  = timeout_q;
    wcnt_d     = '0;
    bus_wait   = 1'b0;
    o_busValid = 1'b0;
    o_busWrite = 1'b0;
    o_busAddr  = 32'd0;
    o_busWData = 32'd0;
    o_busSize  = 2'b00;
    o_stall    = 1'b0;

    case (state_q)
      IDLE: begin
        // Gated by reset so the pipeline sees no stall while reset is held.
        o_stall = reset_x & (Fi_req | Mi_read | Mi_write);
        if (Mi_read || Mi_write) begin
          maddr_d  = Mi_addr;
          mwdata_d = Mi_writeData;
          msize_d  = Mi_memSize;
          mwrite_d = Mi_write;
          faddr_d  = Fi_addr;
          freq_d   = Fi_req;
          state_d  = DATA;
        end else if (Fi_req) begin
          faddr_d  = Fi_addr;
          freq_d   = 1'b1;
          state_d  = FETCH;
        end
      end
      DATA: begin
        o_stall    = 1'b1;
        o_busValid = 1'b1;
        o_busWrite = mwrite_q;
        o_busAddr  = maddr_q;
        o_busWData = mwdata_q;
        o_busSize  = msize_q;
        bus_wait   = ~i_busReady;
        if (i_busReady) begin
          if (!mwrite_q) rdata_d = i_busRData;
          state_d = freq_q ? FETCH : DONE;
        end
      end
      FETCH: begin
        o_stall    = 1'b1;
        o_busValid = 1'b1;
        o_busAddr  = faddr_q;
        o_busSize  = FETCH_SIZE;
        bus_wait   = ~i_busReady;
        if (i_busReady) begin
          inst_d  = i_busRData;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Counter defaults to zero, which covers clearing on ready and on return to IDLE.
    if (bus_wait) begin
      wcnt_d = (&wcnt_q) ? wcnt_q : wcnt_q + 1'b1;
      if ((TIMEOUT_CYC != 0) && (wcnt_d == WD_LIMIT)) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_x) begin
      state_q   <= IDLE;
      maddr_q   <= 32'd0;
      mwdata_q  <= 32'd0;
      msize_q   <= 2'b00;
      mwrite_q  <= 1'b0;
      faddr_q   <= 32'd0;
      freq_q    <= 1'b0;
      inst_q    <= 32'd0;
      rdata_q   <= 32'd0;
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      maddr_q   <= maddr_d;
      mwdata_q  <= mwdata_d;
      msize_q   <= msize_d;
      mwrite_q  <= mwrite_d;
      faddr_q   <= faddr_d;
      freq_q    <= freq_d;
      inst_q    <= inst_d;
      rdata_q   <= rdata_d;
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : randomized step-level check of mem_port_arbiter against a phase-schedule reference model.
// Latency : each step is predicted as IDLE + data phase (waits+1) + fetch phase (waits+1) + DONE.
// Backpressure: the bench plays the memory, answering after a chosen number of wait cycles.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_x;
  logic        Fi_req;
  logic [31:0] Fi_addr;
  logic        Mi_read;
  logic        Mi_write;
  logic [31:0] Mi_addr;
  logic [31:0] Mi_writeData;
  logic [1:0]  Mi_memSize;
  logic        i_busReady;
  logic [31:0] i_busRData;
  logic        o_busValid;
  logic        o_busWrite;
  logic [31:0] o_busAddr;
  logic [31:0] o_busWData;
  logic [1:0]  o_busSize;
  logic [31:0] Fo_inst;
  logic [31:0] Mo_readData;
  logic        o_stall;
  logic        o_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: last captured values and sticky watchdog.
  logic [31:0] exp_inst = 32'd0;
  logic [31:0] exp_rd   = 32'd0;
  bit          to_sticky = 1'b0;

  mem_port_arbiter #(.TIMEOUT_CYC(TO), .FETCH_SIZE(2'b10)) dut (
    .clk(clk), .reset_x(reset_x),
    .Fi_req(Fi_req), .Fi_addr(Fi_addr),
    .Mi_read(Mi_read), .Mi_write(Mi_write), .Mi_addr(Mi_addr),
    .Mi_writeData(Mi_writeData), .Mi_memSize(Mi_memSize),
    .i_busReady(i_busReady), .i_busRData(i_busRData),
    .o_busValid(o_busValid), .o_busWrite(o_busWrite), .o_busAddr(o_busAddr),
    .o_busWData(o_busWData), .o_busSize(o_busSize),
    .Fo_inst(Fo_inst), .Mo_readData(Mo_readData),
    .o_stall(o_stall), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Request inputs are ignored outside IDLE, so scramble them there.
  task automatic garble();
    Fi_req       = 1'($urandom);
    Fi_addr      = $urandom;
    Mi_read      = 1'($urandom);
    Mi_write     = 1'($urandom);
    Mi_addr      = $urandom;
    Mi_writeData = $urandom;
    Mi_memSize   = 2'($urandom);
  endtask

  task automatic check_held(input string ph);
    check({ph, "_inst"}, Fo_inst, exp_inst);
    check({ph, "_rdata"}, Mo_readData, exp_rd);
  endtask

  // One pipeline step; called at the start of a cycle in which the DUT is in IDLE.
  task automatic run_step(input logic fq, input logic mr, input logic mw,
                          input logic [31:0] fa, input logic [31:0] ma,
                          input logic [31:0] wdat, input logic [1:0] ms,
                          input int wd, input int wf,
                          input logic [31:0] rdd, input logic [31:0] rdf);
    logic dat;
    logic [31:0] d_dat;
    dat = mr | mw;
    d_dat = wdat;
    Fi_req = fq; Fi_addr = fa; Mi_read = mr; Mi_write = mw;
    Mi_addr = ma; Mi_writeData = wdat; Mi_memSize = ms;
    i_busReady = 1'($urandom); i_busRData = $urandom;
    #1;
    check("idle_stall", o_stall, fq | dat);
    check("idle_valid", o_busValid, 1'b0);
    check("idle_to", o_timeout, to_sticky);
    next_cyc();
    if (fq | dat) begin
      if (dat) begin
        for (int k = 0; k <= wd; k++) begin
          garble();
          i_busReady = (k == wd);
          i_busRData = (k == wd) ? rdd : $urandom;
          #1;
          check("data_valid", o_busValid, 1'b1);
          check("data_stall", o_stall, 1'b1);
          check("data_write", o_busWrite, mw);
          check("data_addr", o_busAddr, ma);
          check("data_wdata", o_busWData, d_dat);
          check("data_size", o_busSize, ms);
          check("data_to", o_timeout, to_sticky || (k >= TO));
          next_cyc();
        end
        if (wd >= TO) to_sticky = 1'b1;
        if (!mw) exp_rd = rdd;
      end
      if (fq) begin
        for (int k = 0; k <= wf; k++) begin
          garble();
          i_busReady = (k == wf);
          i_busRData = (k == wf) ? rdf : $urandom;
          #1;
          check("fetch_valid", o_busValid, 1'b1);
          check("fetch_stall", o_stall, 1'b1);
          check("fetch_write", o_busWrite, 1'b0);
          check("fetch_addr", o_busAddr, fa);
          check("fetch_wdata", o_busWData, 32'd0);
          check("fetch_size", o_busSize, 2'b10);
          check("fetch_to", o_timeout, to_sticky || (k >= TO));
          next_cyc();
        end
        if (wf >= TO) to_sticky = 1'b1;
        exp_inst = rdf;
      end
      garble();
      i_busReady = 1'($urandom); i_busRData = $urandom;
      #1;
      check("done_stall", o_stall, 1'b0);
      check("done_valid", o_busValid, 1'b0);
      check("done_to", o_timeout, to_sticky);
      check_held("done");
      next_cyc();
    end
  endtask

  initial begin
    reset_x = 1'b0;
    Fi_req = 1'b1; Fi_addr = 32'h0001_0000; Mi_read = 1'b0; Mi_write = 1'b0;
    Mi_addr = 32'd0; Mi_writeData = 32'd0; Mi_memSize = 2'b00;
    i_busReady = 1'b0; i_busRData = 32'd0;
    next_cyc();
    for (int c = 0; c < 2; c++) begin
      #1;
      check("rst_valid", o_busValid, 1'b0);
      check("rst_stall", o_stall, 1'b0);
      check("rst_to", o_timeout, 1'b0);
      check_held("rst");
      next_cyc();
    end
    reset_x = 1'b1;

    // Fetch only, zero-wait.
    run_step(1'b1, 1'b0, 1'b0, 32'h0001_0000, 32'd0, 32'd0, 2'b00, 0, 0, 32'd0, 32'h0000_0013);
    // Load plus fetch, 2 wait cycles on each transaction (8 cycles total).
    run_step(1'b1, 1'b1, 1'b0, 32'h0001_0004, 32'h0000_2000, 32'd0, 2'b10, 2, 2, 32'hDEAD_BEEF, 32'h0000_0093);
    // Store (read and write both set), Mo_readData must keep DEADBEEF.
    run_step(1'b1, 1'b1, 1'b1, 32'h0001_0008, 32'h0000_3000, 32'h55, 2'b00, 1, 0, 32'h1234_5678, 32'h0000_0113);
    // Data only, no fetch.
    run_step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_4000, 32'h0, 2'b01, 0, 0, 32'hCAFE_F00D, 32'h0);
    // No request: state stays IDLE.
    run_step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'b00, 0, 0, 32'h0, 32'h0);

    for (int s = 0; s < 40; s++) begin
      run_step(1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
               2'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom);
    end

    // Watchdog: long data wait trips it, later steps keep it set.
    run_step(1'b1, 1'b1, 1'b0, 32'h0001_0100, 32'h0000_5000, 32'h0, 2'b10, 7, 1, 32'hA5A5_5A5A, 32'h0000_0213);
    run_step(1'b1, 1'b0, 1'b0, 32'h0001_0104, 32'h0, 32'h0, 2'b00, 0, 0, 32'h0, 32'h0000_0293);

    // Reset during the second wait cycle of a data transaction.
    Fi_req = 1'b1; Fi_addr = 32'h0001_0200; Mi_read = 1'b1; Mi_write = 1'b0;
    Mi_addr = 32'h0000_6000; Mi_memSize = 2'b10; i_busReady = 1'b0;
    #1;
    check("mid_idle_stall", o_stall, 1'b1);
    next_cyc();
    garble(); i_busReady = 1'b0;
    #1;
    check("mid_w1_valid", o_busValid, 1'b1);
    next_cyc();
    garble(); i_busReady = 1'b0; reset_x = 1'b0;
    #1;
    check("mid_w2_valid", o_busValid, 1'b1);
    check("mid_w2_addr", o_busAddr, 32'h0000_6000);
    next_cyc();
    garble(); i_busReady = 1'b0;
    #1;
    exp_inst = 32'd0; exp_rd = 32'd0; to_sticky = 1'b0;
    check("mid_rst_valid", o_busValid, 1'b0);
    check("mid_rst_stall", o_stall, 1'b0);
    check("mid_rst_addr", o_busAddr, 32'd0);
    check("mid_rst_to", o_timeout, 1'b0);
    check_held("mid_rst");
    next_cyc();
    reset_x = 1'b1;
    // DUT must be back in IDLE and serve a fresh fetch.
    run_step(1'b1, 1'b0, 1'b0, 32'h0001_0300, 32'h0, 32'h0, 2'b00, 1, 1, 32'h0, 32'h0000_0313);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates one shared, variable-latency unified memory port between instruction fetch (IF) and data access (MEM) for the 5-stage RV32 pipeline. For each pipeline step it serves the data access first, then the fetch. It holds a single stall output high until every access requested in that step has completed. Captured instruction and read data are held in registers for the IF/ID and MEM/WB pipeline registers to sample. A sticky watchdog flags a memory that never answers.

Parameters:
TIMEOUT_CYC, 64, bus-wait cycles in one transaction before o_timeout sets; 0 disables the watchdog
FETCH_SIZE, 2'b10, memSize code driven on fetch transactions (word)

Ports:
clk  in  1  clock, rising edge
reset_x  in  1  reset, synchronous, active-low
Fi_req  in  1  IF requests an instruction this step
Fi_addr  in  32  fetch address (PC)
Mi_read  in  1  MEM load request
Mi_write  in  1  MEM store request
Mi_addr  in  32  data address (ALU result)
Mi_writeData  in  32  store data
Mi_memSize  in  2  access size code, as used by the datapath
i_busReady  in  1  memory completes the current transaction
i_busRData  in  32  memory read data, valid with i_busReady
o_busValid  out  1  transaction request
o_busWrite  out  1  1 = store
o_busAddr  out  32  transaction address
o_busWData  out  32  store data
o_busSize  out  2  transaction size
Fo_inst  out  32  last fetched instruction (registered)
Mo_readData  out  32  last loaded raw word, unextended (registered)
o_stall  out  1  pipeline must not advance
o_timeout  out  1  sticky watchdog error

Behaviour:
- State machine: IDLE, DATA, FETCH, DONE.
- Reset (reset_x=0 at a clock edge):
  - state=IDLE; all outputs and internal registers 0.
  - Applies mid-transaction too: o_busValid drops the next cycle. The transaction is abandoned and the memory must tolerate this.
- IDLE:
  - o_stall = Fi_req|Mi_read|Mi_write (combinational).
  - If Mi_read or Mi_write: latch Mi_addr, Mi_writeData, Mi_memSize, Mi_write, Fi_addr and Fi_req; go to DATA.
  - Else if Fi_req: latch Fi_addr; go to FETCH.
  - Else stay in IDLE.
- DATA:
  - o_busValid=1; bus address, data, size and write come from the latched data request.
  - If Mi_read and Mi_write are both set, the access is a store.
  - On i_busReady: a load captures i_busRData into Mo_readData; a store leaves it unchanged. Then go to FETCH if the latched Fi_req is set, else DONE.
- FETCH:
  - o_busValid=1, o_busWrite=0, o_busAddr = latched Fi_addr, o_busSize=FETCH_SIZE, o_busWData=0.
  - On i_busReady: capture i_busRData into Fo_inst; go to DONE.
- DONE:
  - o_stall=0 for exactly one cycle; the pipeline advances at the end of this cycle.
  - Next state is IDLE, which samples the new step's requests.
- o_stall=1 in DATA and FETCH.
- Bus handshake:
  - i_busReady is sampled only while o_busValid=1; zero-wait (ready in the same cycle as valid) is legal.
  - Address, data and size stay stable while valid and not ready.
  - o_busValid is 0 in IDLE and DONE, so there are never back-to-back transactions without a gap state between steps.
- Latency with a zero-wait memory:
  - fetch only: 3 cycles per step (IDLE, FETCH, DONE);
  - data + fetch: 4 cycles;
  - no request: o_stall=0 and the state stays IDLE.
- Fo_inst and Mo_readData hold their values until overwritten by a later capture. They are valid from the DONE cycle onward.
- Watchdog:
  - A counter increments each cycle in DATA or FETCH with i_busReady=0, and clears on i_busReady and on entry to IDLE.
  - When the counter equals TIMEOUT_CYC (TIMEOUT_CYC≠0), o_timeout sets and stays set until reset. The transaction keeps waiting.
  - The counter saturates; it does not wrap.
- Request inputs are ignored outside IDLE. Changes to them mid-step have no effect.

Test Plan:
- Reset: hold reset_x=0 for 2 cycles with Fi_req=1 -> o_busValid=0, o_stall=0, Fo_inst=0, Mo_readData=0, o_timeout=0. Release -> FETCH entered one cycle later.
- Fetch only, zero-wait memory: Fi_req=1, Fi_addr=32'h0001_0000, i_busRData=32'h0000_0013 -> o_busValid for 1 cycle with that address and size 2'b10. o_stall=1,1,0 over 3 cycles; Fo_inst=32'h13 in the DONE cycle.
- Load plus fetch, memory with 2 wait cycles: Mi_read=1, Mi_addr=32'h2000, memory returns 32'hDEAD_BEEF -> data transaction first (3 valid cycles), then the fetch. Mo_readData=32'hDEAD_BEEF; o_stall low only in the DONE cycle; total 8 cycles.
- Store: Mi_write=1, Mi_read=1, Mi_writeData=32'h55, Mi_memSize=2'b00 -> o_busWrite=1, o_busWData=32'h55, o_busSize=2'b00. Mo_readData keeps its previous value.
- Timeout: TIMEOUT_CYC=4, i_busReady held 0 -> o_timeout rises after 4 waiting cycles and o_stall stays 1. A later i_busReady completes the step but o_timeout stays 1 until reset.
- Reset mid-DATA: assert reset_x=0 during the 2nd wait cycle -> next cycle o_busValid=0, state IDLE, outputs 0.
